// File: rtl/apb_clint_timer_pkg.sv
// CLINT register map, timer width and offset decoder.
// The PRESC offset decodes only when SOPHON_CLINT_PRESCALER_EN is defined.
package CLINT_PKG;

  localparam int MTIME_W = 64;

  localparam logic [31:0] MSIP_OFS        = 32'h000;
  localparam logic [31:0] MTIMECMP_LO_OFS = 32'h008;
  localparam logic [31:0] MTIMECMP_HI_OFS = 32'h00C;
  localparam logic [31:0] MTIME_LO_OFS    = 32'h010;
  localparam logic [31:0] MTIME_HI_OFS    = 32'h014;
  localparam logic [31:0] PRESC_OFS       = 32'h018;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_MTIMECMP_LO,
    SEL_MTIMECMP_HI,
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_PRESC
  } reg_sel_e;

  // Misaligned offsets never match an entry, so they fall into SEL_NONE.
  function automatic reg_sel_e reg_decode(input logic [31:0] ofs);
    case (ofs)
      MSIP_OFS:        return SEL_MSIP;
      MTIMECMP_LO_OFS: return SEL_MTIMECMP_LO;
      MTIMECMP_HI_OFS: return SEL_MTIMECMP_HI;
      MTIME_LO_OFS:    return SEL_MTIME_LO;
      MTIME_HI_OFS:    return SEL_MTIME_HI;
`ifdef SOPHON_CLINT_PRESCALER_EN
      PRESC_OFS:       return SEL_PRESC;
`endif
      default:         return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cc_itf_pkg.sv
// Core-complex interconnect types: 32-bit APB request/response bundles.
package CC_ITF_PKG;

  typedef struct packed {
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
  } apb_d32_req_t;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
  } apb_d32_resps_t;

endpackage

// File: rtl/apb_clint_timer_mtime_cnt.sv
// Free-running 64-bit mtime counter with tick generation.
// SOPHON_CLINT_PRESCALER_EN adds a 16-bit prescaler between clock and tick.
module clint_mtime_cnt
  import CLINT_PKG::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               lo_we,
  input  logic               hi_we,
  input  logic [31:0]        wdata,
`ifdef SOPHON_CLINT_PRESCALER_EN
  input  logic               presc_we,
  input  logic [15:0]        presc_wdata,
  output logic [15:0]        presc,
`endif
  output logic [MTIME_W-1:0] mtime
);

  logic tick;

`ifdef SOPHON_CLINT_PRESCALER_EN
  logic [15:0] presc_cnt;

  assign tick = (presc_cnt == presc);

  // Reprogramming the divider or rewriting mtime restarts the tick phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc     <= '0;
      presc_cnt <= '0;
    end else begin
      if (presc_we) begin
        presc     <= presc_wdata;
        presc_cnt <= '0;
      end else if (lo_we || hi_we || tick) begin
        presc_cnt <= '0;
      end else begin
        presc_cnt <= presc_cnt + 16'd1;
      end
    end
  end
`else
  assign tick = 1'b1;
`endif

  // A half-word write suppresses that cycle's increment; the other half holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime <= '0;
    end else if (lo_we || hi_we) begin
      if (lo_we) mtime[31:0]  <= wdata;
      if (hi_we) mtime[63:32] <= wdata;
    end else if (tick) begin
      mtime <= mtime + MTIME_W'(1);
    end
  end

endmodule

// File: rtl/apb_clint_timer.sv
// APB machine timer / software interrupt source (mtime, mtimecmp, msip).
// Optional prescaler register enabled by SOPHON_CLINT_PRESCALER_EN.
module apb_clint_timer
  import CC_ITF_PKG::*;
  import CLINT_PKG::*;
#(
  parameter int                 APB_ADDR_WIDTH = 12,
  parameter logic [MTIME_W-1:0] MTIMECMP_RST   = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  apb_d32_req_t   apb_req_i,
  output apb_d32_resps_t apb_rsp_o,
  output logic           irq_mti_o,
  output logic           irq_msi_o
);

  logic [31:0]        ofs;
  reg_sel_e           sel;
  logic               access;
  logic               wr;
  logic [31:0]        rdata;
  logic               msip;
  logic [MTIME_W-1:0] mtimecmp;
  logic [MTIME_W-1:0] mtime;
  logic               unused_paddr;

  assign ofs          = 32'(apb_req_i.paddr[APB_ADDR_WIDTH-1:0]);
  assign unused_paddr = ^apb_req_i.paddr[31:APB_ADDR_WIDTH];
  assign sel          = reg_decode(ofs);
  assign access       = apb_req_i.psel & apb_req_i.penable;
  assign wr           = access & apb_req_i.pwrite & (sel != SEL_NONE);

`ifdef SOPHON_CLINT_PRESCALER_EN
  logic [15:0] presc;
`endif

  clint_mtime_cnt u_mtime_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .lo_we       (wr && sel == SEL_MTIME_LO),
    .hi_we       (wr && sel == SEL_MTIME_HI),
    .wdata       (apb_req_i.pwdata),
`ifdef SOPHON_CLINT_PRESCALER_EN
    .presc_we    (wr && sel == SEL_PRESC),
    .presc_wdata (apb_req_i.pwdata[15:0]),
    .presc       (presc),
`endif
    .mtime       (mtime)
  );

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_MSIP:        rdata = {31'b0, msip};
      SEL_MTIMECMP_LO: rdata = mtimecmp[31:0];
      SEL_MTIMECMP_HI: rdata = mtimecmp[63:32];
      SEL_MTIME_LO:    rdata = mtime[31:0];
      SEL_MTIME_HI:    rdata = mtime[63:32];
`ifdef SOPHON_CLINT_PRESCALER_EN
      SEL_PRESC:       rdata = {16'b0, presc};
`endif
      default:         rdata = '0;
    endcase
  end

  assign apb_rsp_o.pready  = 1'b1;
  assign apb_rsp_o.pslverr = access & (sel == SEL_NONE);
  assign apb_rsp_o.prdata  = (access && sel != SEL_NONE) ? rdata : '0;

  // Compare uses the pre-update registers, so irq lags the state by one edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      msip      <= 1'b0;
      mtimecmp  <= MTIMECMP_RST;
      irq_mti_o <= 1'b0;
    end else begin
      if (wr && sel == SEL_MSIP)        msip            <= apb_req_i.pwdata[0];
      if (wr && sel == SEL_MTIMECMP_LO) mtimecmp[31:0]  <= apb_req_i.pwdata;
      if (wr && sel == SEL_MTIMECMP_HI) mtimecmp[63:32] <= apb_req_i.pwdata;
      irq_mti_o <= (mtime >= mtimecmp);
    end
  end

  assign irq_msi_o = msip;

endmodule

// File: tb/tb_apb_clint_timer.sv
// Directed self-checking bench for apb_clint_timer (default or prescaler build).
module tb_apb_clint_timer;
  import CC_ITF_PKG::*;

  logic           clk = 1'b0;
  logic           rst_n;
  apb_d32_req_t   req;
  apb_d32_resps_t rsp;
  logic           irq_mti;
  logic           irq_msi;

  int n_checks = 0;
  int n_fails  = 0;

  apb_clint_timer #(
    .APB_ADDR_WIDTH (12),
    .MTIMECMP_RST   (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .apb_req_i (req),
    .apb_rsp_o (rsp),
    .irq_mti_o (irq_mti),
    .irq_msi_o (irq_msi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Setup phase right after an edge, access phase on the next, sampled before
  // the completing edge; returns #1 after the completing edge.
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    @(posedge clk); #1;
    req.psel    = 1'b1;
    req.penable = 1'b0;
    req.pwrite  = wr;
    req.paddr   = addr;
    req.pwdata  = wdata;
    @(posedge clk); #1;
    req.penable = 1'b1;
    #3;
    rdata = rsp.prdata;
    err   = rsp.pslverr;
    @(posedge clk); #1;
    req.psel    = 1'b0;
    req.penable = 1'b0;
    req.pwrite  = 1'b0;
  endtask

  logic [31:0] rd, rd2;
  logic        er;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_irq_mti", irq_mti, 0);
    check("rst_irq_msi", irq_msi, 0);
    check("rst_pready", rsp.pready, 1);
    check("rst_prdata", rsp.prdata, 0);
    check("rst_pslverr", rsp.pslverr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_irq_mti", irq_mti, 0);
    check("rel_irq_msi", irq_msi, 0);

    apb(0, 32'h008, 0, rd, er); check("cmp_lo_rst", rd, 32'hFFFF_FFFF);
    apb(0, 32'h00C, 0, rd, er); check("cmp_hi_rst", rd, 32'hFFFF_FFFF);

    // Two reads 10 cycles apart
    apb(0, 32'h010, 0, rd, er);
    repeat (7) @(posedge clk);
    apb(0, 32'h010, 0, rd2, er);
    check("mtime_delta10", rd2 - rd, 10);

    // Idle setup phase drives prdata to zero
    @(posedge clk); #1;
    req.psel = 1'b1; req.paddr = 32'h010;
    #1; check("setup_prdata0", rsp.prdata, 0);
    req.psel = 1'b0;

    // MSIP
    apb(1, 32'h000, 32'hFFFF_FFFF, rd, er); check("msi_set", irq_msi, 1);
    apb(0, 32'h000, 0, rd, er);             check("msip_rd1", rd, 32'h1);
    apb(1, 32'h000, 32'h0, rd, er);         check("msi_clr", irq_msi, 0);
    apb(0, 32'h000, 0, rd, er);             check("msip_rd0", rd, 32'h0);
    apb(0, 32'hABC0_0000, 0, rd, er);       check("upper_addr_ignored_err", er, 0);

    // mtime=0 then mtimecmp=100; LO write edge is A, now just after A
    apb(1, 32'h014, 32'h0, rd, er);
    apb(1, 32'h010, 32'h0, rd, er);
    apb(1, 32'h00C, 32'h0, rd, er);
    apb(1, 32'h008, 32'd100, rd, er);
    apb(0, 32'h010, 0, rd, er);
    check("mtime_after_wr", rd, 32'd8);
    // now just after edge A+9; mtime reaches 100 at edge A+100
    repeat (91) @(posedge clk);
    #1; check("mti_before", irq_mti, 0);
    @(posedge clk); #1; check("mti_rise", irq_mti, 1);

    // Raising mtimecmp clears irq one edge after the write edge
    apb(1, 32'h008, 32'hFFFF_FFFF, rd, er); check("mti_at_wr_edge", irq_mti, 1);
    @(posedge clk); #1; check("mti_clear", irq_mti, 0);

    // Wrap: mtimecmp = 0x0000_0000_FFFF_FFFF
    apb(1, 32'h014, 32'hFFFF_FFFF, rd, er);
    apb(1, 32'h010, 32'hFFFF_FFFE, rd, er); check("mti_high_mtime", irq_mti, 1);
    apb(0, 32'h010, 0, rd, er);             check("wrap_lo", rd, 0);
    apb(0, 32'h014, 0, rd, er);             check("wrap_hi", rd, 0);
    check("mti_after_wrap", irq_mti, 0);

    // Error responses
    apb(0, 32'h004, 0, rd, er); check("err004_slv", er, 1); check("err004_data", rd, 0);
    apb(0, 32'h011, 0, rd, er); check("err011_slv", er, 1); check("err011_data", rd, 0);
    apb(1, 32'h004, 32'h1234_5671, rd, er); check("err004_wr_slv", er, 1);
    check("err004_wr_msi", irq_msi, 0);
    apb(0, 32'h000, 0, rd, er); check("err004_msip", rd, 0);
    apb(0, 32'h008, 0, rd, er); check("err004_cmp_lo", rd, 32'hFFFF_FFFF);
    apb(0, 32'h00C, 0, rd, er); check("err004_cmp_hi", rd, 0);

`ifdef SOPHON_CLINT_PRESCALER_EN
    apb(1, 32'h018, 32'hFFFF_0003, rd, er); check("presc_wr_slv", er, 0);
    apb(0, 32'h018, 0, rd, er);             check("presc_rd", rd, 32'h3);
    apb(0, 32'h010, 0, rd, er);
    repeat (5) @(posedge clk);
    apb(0, 32'h010, 0, rd2, er);
    check("presc_delta", rd2 - rd, 2);
`else
    apb(0, 32'h018, 0, rd, er); check("presc_unmapped_slv", er, 1);
    check("presc_unmapped_data", rd, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_clint_timer.md
# apb_clint_timer

- APB-attached machine timer and software-interrupt source.
- Sits on a spare APB slave port of the core-complex interconnect.
- Drives the core's `irq_mti_i` and `irq_msi_i` inputs.
- Holds a free-running 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register and a 1-bit `msip` register, all reachable through 32-bit APB accesses.

## Interface
Parameters:
- `APB_ADDR_WIDTH`, default 12: number of `paddr` bits decoded; upper bits are ignored.
- `MTIMECMP_RST`, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`.

Ports:
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `apb_req_i` in `CC_ITF_PKG::apb_d32_req_t`: fields used are `paddr`, `pwdata`, `pwrite`, `psel`, `penable`.
- `apb_rsp_o` out `CC_ITF_PKG::apb_d32_resps_t`: `prdata`, `pready`, `pslverr`.
- `irq_mti_o` out 1: machine timer interrupt, level.
- `irq_msi_o` out 1: machine software interrupt, level.

## Operation
Register map (offset = `paddr[APB_ADDR_WIDTH-1:0]`):
- 0x000 MSIP: bit0 = `msip`; bits 31:1 read 0, writes ignored.
- 0x008 / 0x00C: MTIMECMP_LO / MTIMECMP_HI.
- 0x010 / 0x014: MTIME_LO / MTIME_HI.
- 0x018 PRESC: present only with the macro (see Configuration).

Access rules:
- An access completes when `psel & penable` is high. Zero wait states: `pready` is constantly 1.
- Writes take effect at the clock edge that ends the access phase.
- Reads return the current register value combinationally in the access phase.
- Unmapped offset or `paddr[1:0] != 0`: `pslverr`=1, `prdata`=0, no state change.
- `prdata` is 0 whenever no access is completing.

`mtime` behaviour:
- Increments by 1 on each tick. Without the macro a tick occurs every cycle.
- Wraps from 2^64-1 to 0 with no flag.
- A write to MTIME_LO or MTIME_HI in the same cycle as a tick: the write wins and no increment happens that cycle. The unwritten half keeps its old value, with no carry.
- A 64-bit read is not atomic; software reads HI, LO, HI again.

Interrupt outputs:
- `irq_mti_o` is registered: `irq_mti_o <= (mtime >= mtimecmp)`, unsigned 64-bit compare using the pre-update register values.
- `irq_msi_o` is the `msip` flop, driven directly.

Reset values:
- `mtime`=0, `mtimecmp`=`MTIMECMP_RST`, `msip`=0, PRESC=0, prescale counter=0.
- `irq_mti_o`=0, `irq_msi_o`=0.
- `apb_rsp_o`: `pready`=1, `prdata`=0, `pslverr`=0.

An asserted reset during an access aborts it. No partial write survives.

## Timing
- Read latency: 0 cycles (same cycle as `penable`).
- Write to MSIP: `irq_msi_o` changes at the end-of-access edge.
- `irq_mti_o` latency:
  - 1 cycle after the `mtime`/`mtimecmp` values that satisfy the compare are present in the registers.
  - After a write making `mtimecmp <= mtime`, `irq_mti_o` rises 2 edges after the access-phase edge (write edge, then compare edge).
- Clearing: a write raising `mtimecmp` above `mtime` deasserts `irq_mti_o` one edge after the write edge.
- Writing MTIMECMP_HI then MTIMECMP_LO can glitch `irq_mti_o` between the two writes. This is accepted; software writes LO=all-ones first.

## Configuration
Macro `SOPHON_CLINT_PRESCALER_EN`.

Defined:
- PRESC at 0x018 is mapped: bits 15:0 read/write, upper bits read 0.
- A 16-bit prescale counter counts 0..PRESC. A tick occurs when counter == PRESC, and the counter then returns to 0.
- PRESC=0 gives a tick every cycle.
- A write to PRESC also clears the prescale counter.
- An `mtime` write clears the prescale counter too.

Undefined:
- Offset 0x018 is unmapped (`pslverr`).
- Tick every cycle; no prescaler flops exist.

## Structure
- New package `CLINT_PKG` holds:
  - the offset constants `MSIP_OFS`, `MTIMECMP_LO_OFS`, `MTIMECMP_HI_OFS`, `MTIME_LO_OFS`, `MTIME_HI_OFS`, `PRESC_OFS`;
  - the width localparam `MTIME_W`=64.
- One sub-module, `clint_mtime_cnt`, owns:
  - the 64-bit counter, tick generation and the optional prescaler;
  - inputs: LO/HI write enables and write data.
- The top level does APB decode, holds `mtimecmp`/`msip`, and performs the compare.

## Test plan
- Reset release: `irq_mti_o`=0 and `irq_msi_o`=0. Read MTIME_LO twice, 10 cycles apart; values differ by 10.
- Write MSIP=1: `irq_msi_o`=1 after the access edge. Write 0: it drops. A read returns 0x1, and 0x0 after the clear.
- Write MTIMECMP_HI=0, MTIMECMP_LO=100, with MTIME=0 written first: `irq_mti_o` rises exactly when `mtime` reaches 100, plus 1 cycle.
- Write MTIME={HI=0xFFFF_FFFF, LO=0xFFFF_FFFE}: after 2 ticks MTIME reads 0/0, and `irq_mti_o` follows the new compare result.
- Read at offset 0x004 and at 0x011: `pslverr`=1 and `prdata`=0. A write at 0x004 changes no register.
- With the macro, write PRESC=3: MTIME_LO advances by 1 every 4 cycles. Without the macro, offset 0x018 returns `pslverr`=1.
